// File: rtl/timer_pkg.sv
// Shared timer types: slave-mode encodings, controller FSM states and the
// CEN write-latency grace window length.
package timer_pkg;

  typedef enum logic [2:0] {
    SMS_INT     = 3'd0,
    SMS_ENC1    = 3'd1,
    SMS_ENC2    = 3'd2,
    SMS_RSVD    = 3'd3,
    SMS_RESET   = 3'd4,
    SMS_GATED   = 3'd5,
    SMS_TRIGGER = 3'd6,
    SMS_EXT1    = 3'd7
  } sms_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } smc_state_e;

  // Cycles after a CEN-set request during which a low cen_i is still stale.
  localparam int CEN_GRACE_CYC = 2;

endpackage

// File: rtl/trigger_sync_edge.sv
// Multi-flop synchronizer followed by a registered edge detector.
// sync_o, rise_o and fall_o are all registered and mutually aligned, so a
// consumer sees the level and its edge strobe in the same cycle.
module trigger_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic aresetn_i,
  input  logic a_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the chain and derive edges against the previous level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
    prev_d = sync_last;
    rise_d = sync_last & ~prev_q;
    fall_d = ~sync_last & prev_q;
  end

  // Synchronizer, previous-level and edge strobe registers.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/slave_mode_controller.sv
// Timer slave-mode controller: sequences the counter from the synchronized
// trigger according to SMS and produces registered enable/reinit/CEN-set/TIF.
module slave_mode_controller
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       aresetn_i,
  input  logic [2:0] sms_i,
  input  logic       trgi_i,
  input  logic       cen_i,
  input  logic       ug_i,
  output logic       cnt_en_o,
  output logic       cnt_rst_o,
  output logic       cen_set_o,
  output logic       tif_o
);

  localparam int GRACE_W = $clog2(CEN_GRACE_CYC + 1);

  logic               trg_s, trg_rise, trg_fall;
  smc_state_e         state_q, state_d;
  sms_e               sms_q, sms_d;
  logic               cen_prev_q, cen_prev_d;
  logic [GRACE_W-1:0] grace_q, grace_d;
  logic               cnt_en_q, cnt_en_d;
  logic               cnt_rst_q, cnt_rst_d;
  logic               cen_set_q, cen_set_d;
  logic               tif_q, tif_d;
  logic               mode_chg;
  logic               cen_fall;

  trigger_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_trg_sync (
    .clk_i    (clk_i),
    .aresetn_i(aresetn_i),
    .a_i      (trgi_i),
    .sync_o   (trg_s),
    .rise_o   (trg_rise),
    .fall_o   (trg_fall)
  );

  assign mode_chg = (sms_e'(sms_i) != sms_q);
  assign cen_fall = cen_prev_q & ~cen_i;

  // Next-state and next-output logic; a mode change silences everything and restarts from IDLE.
  always_comb begin
    state_d    = state_q;
    sms_d      = sms_e'(sms_i);
    cen_prev_d = cen_i;
    cnt_en_d   = 1'b0;
    cnt_rst_d  = ug_i;
    cen_set_d  = 1'b0;
    tif_d      = 1'b0;
    if (cen_set_q) begin
      grace_d = GRACE_W'(CEN_GRACE_CYC);
    end else if (grace_q != '0) begin
      grace_d = grace_q - GRACE_W'(1);
    end else begin
      grace_d = grace_q;
    end

    case (state_q)
      IDLE: begin
        if (sms_q == SMS_TRIGGER) begin
          state_d = ARMED;
        end else if (cen_i) begin
          state_d = RUN;
        end
      end
      ARMED: begin
        if (trg_rise) begin
          state_d   = RUN;
          cnt_en_d  = 1'b1;
          cen_set_d = 1'b1;
          tif_d     = 1'b1;
        end
      end
      RUN: begin
        case (sms_q)
          SMS_RESET: begin
            cnt_en_d = 1'b1;
            if (trg_rise) begin
              cnt_rst_d = 1'b1;
              tif_d     = 1'b1;
            end
          end
          SMS_GATED: begin
            cnt_en_d = trg_s;
            tif_d    = trg_rise | trg_fall;
          end
          SMS_TRIGGER: begin
            cnt_en_d = 1'b1;
            tif_d    = trg_rise;
          end
          SMS_EXT1: begin
            cnt_en_d = trg_rise;
            tif_d    = trg_rise;
          end
          default: begin
            cnt_en_d = 1'b1;
          end
        endcase
        if (sms_q == SMS_TRIGGER) begin
          if (cen_fall && (grace_q == '0)) begin
            state_d = IDLE;
          end
        end else if (!cen_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mode_chg) begin
      state_d   = IDLE;
      cnt_en_d  = 1'b0;
      cnt_rst_d = 1'b0;
      cen_set_d = 1'b0;
      tif_d     = 1'b0;
    end
  end

  // State, mode, CEN history and output registers.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q    <= IDLE;
      sms_q      <= SMS_INT;
      cen_prev_q <= 1'b0;
      grace_q    <= '0;
      cnt_en_q   <= 1'b0;
      cnt_rst_q  <= 1'b0;
      cen_set_q  <= 1'b0;
      tif_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sms_q      <= sms_d;
      cen_prev_q <= cen_prev_d;
      grace_q    <= grace_d;
      cnt_en_q   <= cnt_en_d;
      cnt_rst_q  <= cnt_rst_d;
      cen_set_q  <= cen_set_d;
      tif_q      <= tif_d;
    end
  end

  assign cnt_en_o  = cnt_en_q;
  assign cnt_rst_o = cnt_rst_q;
  assign cen_set_o = cen_set_q;
  assign tif_o     = tif_q;

endmodule
